btn_debounce: RTL and testbench

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/btn_debounce.sv | 176 +++++++++++++++++
 tb/tb_btn_debounce.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// Button debouncer and switch synchronizer for the operand/opcode entry front end.
// Switches are only synchronized. Each of the three buttons has a 2-flop synchronizer and
// its own debounce FSM. Accepted presses are turned into registered one-cycle pulses.
// The pulses are arbitrated A > B > OP, so at most one pulse is high in any cycle.
module btn_debounce #(
  parameter int unsigned SIZE_SW         = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic [SIZE_SW-1:0] i_sw,
  input  logic               i_btn_a,
  input  logic               i_btn_b,
  input  logic               i_btn_op,
  output logic [SIZE_SW-1:0] o_sw,
  output logic               o_btn_a,
  output logic               o_btn_b,
  output logic               o_btn_op
);

  // Button index 0 = A, 1 = B, 2 = OP. The lowest index has the highest priority.
  localparam int NUM_BTN = 3;

  // The counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StReleased,
    StPressWait,
    StPressed,
    StReleaseWait
  } state_e;

  // Synchronizers
  logic [SIZE_SW-1:0] r_sw_meta;
  logic [SIZE_SW-1:0] r_sw_sync;
  logic [NUM_BTN-1:0] w_btn_raw;
  logic [NUM_BTN-1:0] r_btn_meta;
  logic [NUM_BTN-1:0] r_btn_sync;

  // Per-button debounce FSMs
  state_e             r_state     [NUM_BTN];
  state_e             w_state_nxt [NUM_BTN];
  logic [CNT_W-1:0]   r_cnt       [NUM_BTN];
  logic [CNT_W-1:0]   w_cnt_nxt   [NUM_BTN];
  logic [NUM_BTN-1:0] w_accept;

  // Pending flags and pulse arbitration
  logic [NUM_BTN-1:0] r_pend;
  logic [NUM_BTN-1:0] w_pend_all;
  logic [NUM_BTN-1:0] w_pend_nxt;
  logic [NUM_BTN-1:0] w_grant;
  logic [NUM_BTN-1:0] r_pulse;

  assign w_btn_raw = {i_btn_op, i_btn_b, i_btn_a};

  // Two-flop synchronizers for every switch bit and every raw button.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sw_meta  <= '0;
      r_sw_sync  <= '0;
      r_btn_meta <= '0;
      r_btn_sync <= '0;
    end else begin
      r_sw_meta  <= i_sw;
      r_sw_sync  <= r_sw_meta;
      r_btn_meta <= w_btn_raw;
      r_btn_sync <= r_btn_meta;
    end
  end

  // FSM state and counter registers, one set per button.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        r_state[i] <= StReleased;
        r_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
    end
  end

  // Next-state and counter logic. Any sample of the opposite level restarts the wait.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      unique case (r_state[i])
        StReleased: begin
          if (r_btn_sync[i]) begin
            w_state_nxt[i] = StPressWait;
            w_cnt_nxt[i]   = '0;
          end
        end
        StPressWait: begin
          if (!r_btn_sync[i]) begin
            w_state_nxt[i] = StReleased;
            w_cnt_nxt[i]   = '0;
          end else if (r_cnt[i] == CNT_LAST) begin
            w_state_nxt[i] = StPressed;
            w_cnt_nxt[i]   = '0;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
          end
        end
        StPressed: begin
          if (!r_btn_sync[i]) begin
            w_state_nxt[i] = StReleaseWait;
            w_cnt_nxt[i]   = '0;
          end
        end
        StReleaseWait: begin
          if (r_btn_sync[i]) begin
            w_state_nxt[i] = StPressed;
            w_cnt_nxt[i]   = '0;
          end else if (r_cnt[i] == CNT_LAST) begin
            w_state_nxt[i] = StReleased;
            w_cnt_nxt[i]   = '0;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt[i] = StReleased;
          w_cnt_nxt[i]   = '0;
        end
      endcase
    end
  end

  // FSM output: a press is accepted on the last high cycle of the press wait.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      w_accept[i] = (r_state[i] == StPressWait) && r_btn_sync[i] && (r_cnt[i] == CNT_LAST);
    end
  end

  // Fixed-priority grant. An acceptance in this cycle competes directly, so an
  // uncontended press reaches the pulse register without an extra cycle of delay.
  // Any flag that loses stays pending, and a repeat acceptance merges into it.
  always_comb begin
    w_pend_all = r_pend | w_accept;
    w_grant    = '0;
    if (w_pend_all[0]) begin
      w_grant[0] = 1'b1;
    end else if (w_pend_all[1]) begin
      w_grant[1] = 1'b1;
    end else if (w_pend_all[2]) begin
      w_grant[2] = 1'b1;
    end
    w_pend_nxt = w_pend_all & ~w_grant;
  end

  // Pending flags and registered one-hot pulse outputs.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pend  <= '0;
      r_pulse <= '0;
    end else begin
      r_pend  <= w_pend_nxt;
      r_pulse <= w_grant;
    end
  end

  assign o_sw     = r_sw_sync;
  assign o_btn_a  = r_pulse[0];
  assign o_btn_b  = r_pulse[1];
  assign o_btn_op = r_pulse[2];

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce with DEBOUNCE_CYCLES=4.
// The reference model tracks an accepted level per button. It also tracks the run length
// of synchronized samples that disagree with that level. The level flips once the run
// reaches DEBOUNCE_CYCLES+1 samples, which gives a latency of DEBOUNCE_CYCLES+3 edges.
// Accepted presses go through A > B > OP pending flags.
module tb_btn_debounce;

  localparam int D = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] sw = '0;
  logic         a = 1'b0;
  logic         b = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] o_sw;
  logic         o_btn_a;
  logic         o_btn_b;
  logic         o_btn_op;

  btn_debounce #(
    .SIZE_SW        (W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .i_sw     (sw),
    .i_btn_a  (a),
    .i_btn_b  (b),
    .i_btn_op (op),
    .o_sw     (o_sw),
    .o_btn_a  (o_btn_a),
    .o_btn_b  (o_btn_b),
    .o_btn_op (o_btn_op)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit   [2:0]   m_s1 = '0;
  bit   [2:0]   m_s2 = '0;
  bit   [2:0]   m_lvl = '0;
  int           m_run [3];
  bit   [2:0]   m_pend = '0;
  bit   [2:0]   m_pulse = '0;
  logic [W-1:0] m_sw1 = '0;
  logic [W-1:0] m_sw2 = '0;

  // Observation bookkeeping
  int edge_no = 0;
  int npulse [3];
  int first_edge [3];
  int base = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0;
    m_s2 = '0;
    m_lvl = '0;
    m_pend = '0;
    m_pulse = '0;
    m_sw1 = '0;
    m_sw2 = '0;
    for (int i = 0; i < 3; i++) m_run[i] = 0;
  endtask

  task automatic model_edge(input bit [2:0] raw, input logic [W-1:0] swv);
    bit [2:0] acc;
    bit [2:0] pend;
    bit       found;
    acc = '0;
    for (int i = 0; i < 3; i++) begin
      if (m_s2[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == D + 1) begin
          m_lvl[i] = m_s2[i];
          m_run[i] = 0;
          if (m_s2[i]) acc[i] = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
    m_sw2 = m_sw1;
    m_sw1 = swv;
    pend = m_pend | acc;
    m_pulse = '0;
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!found && pend[i]) begin
        m_pulse[i] = 1'b1;
        pend[i] = 1'b0;
        found = 1'b1;
      end
    end
    m_pend = pend;
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 3; i++) begin
      npulse[i] = 0;
      first_edge[i] = -1;
    end
  endtask

  task automatic check_outputs();
    bit [2:0] obs;
    obs = {o_btn_op, o_btn_b, o_btn_a};
    chk("o_btn_a", {31'b0, o_btn_a}, {31'b0, m_pulse[0]});
    chk("o_btn_b", {31'b0, o_btn_b}, {31'b0, m_pulse[1]});
    chk("o_btn_op", {31'b0, o_btn_op}, {31'b0, m_pulse[2]});
    chk("o_sw", {16'b0, o_sw}, {16'b0, m_sw2});
    chk("pulse_onehot", {31'b0, ($countones(obs) <= 1)}, 32'd1);
  endtask

  // One clock edge: advance the model, then check outputs 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge({op, b, a}, sw);
    edge_no++;
    #1;
    check_outputs();
    if (o_btn_a) begin npulse[0]++; if (first_edge[0] < 0) first_edge[0] = edge_no; end
    if (o_btn_b) begin npulse[1]++; if (first_edge[1] < 0) first_edge[1] = edge_no; end
    if (o_btn_op) begin npulse[2]++; if (first_edge[2] < 0) first_edge[2] = edge_no; end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_o_sw", {16'b0, o_sw}, 32'd0);
    chk("rst_pulses", {29'b0, o_btn_op, o_btn_b, o_btn_a}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) m_run[i] = 0;
    clear_obs();

    // Reset state
    #1;
    assert_reset();
    steps(2);
    rst_n = 1'b1;
    steps(3);

    // Switch path: two-cycle latency, cleared immediately by reset
    sw = 16'hA5C3;
    step();
    chk("sw_1cyc", {16'b0, o_sw}, 32'd0);
    step();
    chk("sw_2cyc", {16'b0, o_sw}, 32'h0000A5C3);
    assert_reset();
    steps(2);
    rst_n = 1'b1;
    steps(3);

    // Single long press on A
    clear_obs();
    a = 1'b1;
    base = edge_no;
    steps(20);
    a = 1'b0;
    steps(15);
    chk("a_count", npulse[0], 1);
    chk("a_latency", first_edge[0] - base, 7);
    chk("a_no_b", npulse[1], 0);
    chk("a_no_op", npulse[2], 0);

    // Glitchy B never stays high long enough
    clear_obs();
    b = 1'b1; steps(2);
    b = 1'b0; steps(1);
    b = 1'b1; steps(2);
    b = 1'b0; steps(15);
    chk("bounce_a", npulse[0], 0);
    chk("bounce_b", npulse[1], 0);
    chk("bounce_op", npulse[2], 0);

    // Simultaneous presses serialize as A, B, OP
    clear_obs();
    a = 1'b1; b = 1'b1; op = 1'b1;
    base = edge_no;
    steps(20);
    a = 1'b0; b = 1'b0; op = 1'b0;
    steps(15);
    chk("sim_count_a", npulse[0], 1);
    chk("sim_count_b", npulse[1], 1);
    chk("sim_count_op", npulse[2], 1);
    chk("sim_lat_a", first_edge[0] - base, 7);
    chk("sim_order_b", first_edge[1] - first_edge[0], 1);
    chk("sim_order_op", first_edge[2] - first_edge[0], 2);

    // OP press, release with a one-cycle bounce, then a second real press
    clear_obs();
    op = 1'b1; steps(12);
    op = 1'b0; steps(2);
    op = 1'b1; steps(1);
    op = 1'b0; steps(15);
    op = 1'b1; steps(12);
    op = 1'b0; steps(15);
    chk("op_two_pulses", npulse[2], 2);

    // Reset in the middle of the press wait, button held through release
    clear_obs();
    a = 1'b1;
    steps(6);
    assert_reset();
    steps(2);
    chk("midcount_no_pulse", npulse[0], 0);
    rst_n = 1'b1;
    base = edge_no;
    steps(15);
    a = 1'b0;
    steps(15);
    chk("held_count", npulse[0], 1);
    chk("held_latency", first_edge[0] - base, 7);

    // Reset with B and OP still pending discards them
    clear_obs();
    a = 1'b1; b = 1'b1; op = 1'b1;
    steps(7);
    chk("pend_a_pulse", npulse[0], 1);
    assert_reset();
    a = 1'b0; b = 1'b0; op = 1'b0;
    steps(2);
    rst_n = 1'b1;
    clear_obs();
    steps(15);
    chk("pend_drop_b", npulse[1], 0);
    chk("pend_drop_op", npulse[2], 0);

    // Random toggling checked cycle by cycle against the model
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 9) == 0) a = ~a;
      if ($urandom_range(0, 9) == 0) b = ~b;
      if ($urandom_range(0, 9) == 0) op = ~op;
      if ($urandom_range(0, 3) == 0) sw = W'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        assert_reset();
        steps(2);
        rst_n = 1'b1;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
